aes_subbytes_pipe: RTL and testbench

AES_SUBBYTES_PIPE -- requirements
Module: aes_subbytes_pipe

---
 rtl/aes_sbox_pkg.sv | 52 +++++
 rtl/aes_subbytes_pipe_if.sv | 27 ++
 rtl/aes_sbox_byte.sv | 22 ++
 rtl/aes_subbytes_pipe.sv | 103 ++++++++++
 tb/tb_aes_subbytes_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sbox_pkg.sv
// AES S-box package.
// Holds the FIPS-197 forward and inverse substitution tables, a per-byte
// lookup helper and the default lane count shared by the interface and the
// pipeline. Imported by aes_sbox_byte and aes_subbytes_pipe.
package aes_sbox_pkg;

  localparam int LANES_DEFAULT = 4;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Per-byte substitution; inv selects the inverse table.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] value, input logic inv);
    return inv ? SBOX_INV[value] : SBOX_FWD[value];
  endfunction

endpackage

// File: rtl/aes_subbytes_pipe_if.sv
// Handshake bundle for aes_subbytes_pipe.
// Upstream:   in_valid, in_ready, in_data[8*LANES], in_inv.
// Downstream: out_valid, out_ready, out_data[8*LANES], out_inv.
// slave  - the pipeline side (consumes in_*, produces out_*).
// master - the environment side (produces in_*, consumes out_*).
interface aes_subbytes_pipe_if #(
  parameter int LANES = aes_sbox_pkg::LANES_DEFAULT
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_inv;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic                 out_inv;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, out_inv
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, out_inv
  );
endinterface

// File: rtl/aes_sbox_byte.sv
// Single-byte AES substitution (combinational).
// Ports: value (8-bit byte to substitute), inv (1 = inverse table),
//        result (8-bit substituted byte).
// With AES_SUBBYTES_INV_EN undefined only the forward table is built and
// inv has no effect.
module aes_sbox_byte
  import aes_sbox_pkg::*;
(
  input  logic [7:0] value,
  input  logic       inv,
  output logic [7:0] result
);

`ifdef AES_SUBBYTES_INV_EN
  assign result = sbox_lookup(value, inv);
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result     = SBOX_FWD[value];
`endif

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Two-stage AES SubBytes pipeline with valid/ready handshakes.
// Ports: clk (rising edge), rst_n (asynchronous, active low),
//        bus (aes_subbytes_pipe_if.slave: in_valid/in_ready/in_data/in_inv,
//             out_valid/out_ready/out_data/out_inv),
//        word_cnt (words accepted since reset, wraps silently).
// Stage 1 registers the input word and its mode; stage 2 registers the
// per-lane S-box result. Each stage loads when empty or when it drains in
// the same cycle, giving one word per cycle with out_ready held high.
// Macro AES_SUBBYTES_INV_EN: when defined, in_inv picks the inverse table per
// word; otherwise in_inv is ignored and out_inv stays 0.
module aes_subbytes_pipe
  import aes_sbox_pkg::*;
#(
  parameter int LANES = LANES_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_subbytes_pipe_if.slave bus,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int W = 8 * LANES;

  logic             s1_valid_reg;
  logic [W-1:0]     s1_data_reg;
  logic             s1_inv_reg;
  logic             out_valid_reg;
  logic [W-1:0]     out_data_reg;
  logic             out_inv_reg;
  logic [CNT_W-1:0] word_cnt_reg;

  logic             s1_load;
  logic             s2_load;
  logic             accept;
  logic             mode_next;
  logic [W-1:0]     lane_result;

  // Stage 2 can take new content when empty or when its word leaves now;
  // stage 1 likewise, so a full pipe with a stalled output blocks input.
  assign s2_load = !out_valid_reg || bus.out_ready;
  assign s1_load = !s1_valid_reg || s2_load;
  assign accept  = bus.in_valid && s1_load;

`ifdef AES_SUBBYTES_INV_EN
  assign mode_next = bus.in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
  assign mode_next     = 1'b0;
`endif

  // Stage 1: capture word and its mode so the mode travels with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_inv_reg   <= 1'b0;
      word_cnt_reg <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= bus.in_valid;
      end
      if (accept) begin
        s1_data_reg  <= bus.in_data;
        s1_inv_reg   <= mode_next;
        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end
    end
  end

  // One substitution unit per byte lane; lane order is preserved.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    aes_sbox_byte u_sbox (
      .value  (s1_data_reg[8*gi +: 8]),
      .inv    (s1_inv_reg),
      .result (lane_result[8*gi +: 8])
    );
  end

  // Stage 2: output register. Holds steady while stalled; data is only
  // overwritten when a real word arrives from stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_inv_reg   <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= lane_result;
        out_inv_reg  <= s1_inv_reg;
      end
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_inv   = out_inv_reg;
  assign word_cnt      = word_cnt_reg;

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Scoreboard bench for aes_subbytes_pipe (LANES=4, CNT_W=4).
// The reference S-box is derived from GF(2^8) inversion plus the AES affine
// map; the inverse table is the inversion of that mapping.
module tb_aes_subbytes_pipe;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int W     = 8 * LANES;

`ifdef AES_SUBBYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] word_cnt;

  aes_subbytes_pipe_if #(.LANES(LANES)) bus ();

  aes_subbytes_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         inv;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];
  int         n_vec = 0;
  int         n_err = 0;
  int         ready_pct = 100;
  int         cnt_model = 0;
  int         n_out = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       carry;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      carry = a[7];
      a = {a[6:0], 1'b0};
      if (carry) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_ref();
    logic [7:0] x, y, v, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      v = 8'h00;
      for (int j = 1; j < 256; j++) begin
        y = 8'(j);
        if (x != 8'h00 && gmul(x, y) == 8'h01) v = y;
      end
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      ref_fwd[i] = s;
      ref_inv[s] = x;
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic inv);
    exp_t r;
    r.inv = inv & INV_EN;
    for (int l = 0; l < LANES; l++)
      r.data[8*l +: 8] = r.inv ? ref_inv[d[8*l +: 8]] : ref_fwd[d[8*l +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One driven cycle: inputs change on the falling edge, acceptance is
  // judged just before the rising edge that commits it.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic inv, output bit acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_inv    = inv;
    bus.out_ready = (int'($urandom_range(99)) < ready_pct);
    #1;
    acc = v && bus.in_ready;
    if (acc) sb_q.push_back(model(d, inv));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      cycle(1'b1, d, inv, acc);
      n++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: word %h not accepted, required within 200 cycles", d);
    end
  endtask

  // Monitor: checks word count, output stability under stall and pops the
  // scoreboard on every completed output transfer.
  logic         hold;
  logic [W-1:0] hold_data;
  logic         hold_inv;
  initial begin
    exp_t e;
    hold = 1'b0; hold_data = '0; hold_inv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cnt_model = 0;
        hold = 1'b0;
      end else begin
        check("word_cnt", 64'(word_cnt), 64'(cnt_model % 16));
        if (hold) begin
          check("stall_valid", 64'(bus.out_valid), 64'(1));
          check("stall_data", 64'(bus.out_data), 64'(hold_data));
          check("stall_inv", 64'(bus.out_inv), 64'(hold_inv));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got data=%h inv=%b, required no output", bus.out_data, bus.out_inv);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e.data));
            check("out_inv", 64'(bus.out_inv), 64'(e.inv));
            n_out++;
            $display("out #%0d data=%h inv=%b", n_out, bus.out_data, bus.out_inv);
          end
        end
        hold      = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_inv  = bus.out_inv;
        if (bus.in_valid && bus.in_ready) cnt_model = cnt_model + 1;
      end
    end
  end

  initial begin
    bit           acc;
    int           n;
    logic [W-1:0] w;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_inv = 1'b0; bus.out_ready = 1'b0;
    build_ref();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_word_cnt", 64'(word_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'(1));

    // Forward vector and exact two-cycle latency
    ready_pct = 100;
    send(32'h00010253, 1'b0);
    idle(1);
    check("lat1_out_valid", 64'(bus.out_valid), 64'(0));
    idle(1);
    check("lat2_out_valid", 64'(bus.out_valid), 64'(1));
    check("lat2_out_data", 64'(bus.out_data), 64'(32'h637c77ed));

    // Inverse-mode vectors (forward results expected without the feature)
    send(32'h637c77ed, 1'b1);
    send(32'h16161616, 1'b1);
    send(32'h00010253, 1'b0);
    idle(4);

    // Backpressure: two accepts fill the pipe, then input must stall
    ready_pct = 0;
    send(32'h11223344, 1'b0);
    send(32'h55667788, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h99aabbcc, 1'b0, acc);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
    end
    ready_pct = 100;
    send(32'h99aabbcc, 1'b0);
    send(32'hddeeff00, 1'b1);
    send(32'h0f1e2d3c, 1'b0);
    idle(5);

    // Reset with both stages full
    ready_pct = 0;
    send(32'hcafef00d, 1'b0);
    send(32'hdeadbeef, 1'b1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_word_cnt", 64'(word_cnt), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    ready_pct = 100;
    idle(5);

    // Counter wrap: 17 accepts on a 4-bit counter
    for (int i = 0; i < 17; i++) send(W'($urandom), 1'($urandom_range(1)));
    idle(3);
    check("wrap_word_cnt", 64'(word_cnt), 64'(1));

    // Every byte value in every lane, random mode and random backpressure
    ready_pct = 70;
    for (int i = 0; i < 256; i++) begin
      for (int l = 0; l < LANES; l++) w[8*l +: 8] = 8'((i + 67 * l) % 256);
      if ($urandom_range(3) == 0) idle(1);
      send(w, 1'($urandom_range(1)));
    end

    // Drain
    ready_pct = 100;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    check("drain_pending", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
